// File: rtl/prog_clock_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider_pkg
// Purpose  : Shared defaults and output-mode encodings for the programmable
//            clock/event divider.
// Revision : 1.0 - initial release
// ============================================================================
package prog_clock_divider_pkg;

  // Default counter/divisor width and reset divisor
  localparam int WIDTH_DEFAULT       = 8;
  localparam int DEFAULT_DIV_DEFAULT = 6;

  // Output mode encodings
  localparam logic MODE_TOGGLE = 1'b0;  // square wave, toggles on each wrap
  localparam logic MODE_PULSE  = 1'b1;  // out mirrors the terminal tick

endpackage : prog_clock_divider_pkg
`default_nettype wire

// File: rtl/prog_clock_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider_if
// Purpose  : Control and status bundle of the programmable clock divider.
//            The master drives enable/load/divisor/mode, the slave (divider)
//            returns count, active divisor, tick and divided output.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_clock_divider_if
  import prog_clock_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] div_in;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_q;
  logic             tick;
  logic             out;

  modport master (
    output en, load, div_in, mode,
    input  count, div_q, tick, out
  );

  modport slave (
    input  en, load, div_in, mode,
    output count, div_q, tick, out
  );

endinterface : prog_clock_divider_if
`default_nettype wire

// File: rtl/prog_clock_divider_count_incrementer.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider_count_incrementer
// Purpose  : WIDTH-bit ripple +1 built from full_adder cells. The divider
//            never increments past 2^WIDTH-2, so the carry out of the top
//            bit is never needed and the top stage is a plain sum bit.
// Revision : 1.0 - initial release
// ============================================================================
module prog_clock_divider_count_incrementer #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_sum
);

  logic [WIDTH-1:0] w_carry;

  // Carry-in of one gives the +1
  assign w_carry[0] = 1'b1;

  generate
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_stage
      full_adder u_fa (
        .i_a   (i_a[i]),
        .i_b   (1'b0),
        .i_cin (w_carry[i]),
        .o_sum (o_sum[i]),
        .o_cout(w_carry[i+1])
      );
    end
  endgenerate

  // Top bit: sum only, its carry out can never be set by the divider
  assign o_sum[WIDTH-1] = i_a[WIDTH-1] ^ w_carry[WIDTH-1];

endmodule : prog_clock_divider_count_incrementer

// ============================================================================
// Module   : full_adder
// Purpose  : Single-bit full adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule : full_adder
`default_nettype wire

// File: rtl/prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : prog_clock_divider
// Purpose  : Run-time programmable clock/event divider. Counts enabled cycles
//            modulo a loadable divisor, emits a one-cycle terminal tick and a
//            divided output (square wave or single pulse).
// Revision : 1.0 - initial release
// ============================================================================
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  prog_clock_divider_if.slave bus
);

  localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_div_q;
  logic             r_tick;
  logic             r_out;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_count_inc;
  logic             w_hit;

  // Terminal value; a zero divisor behaves as divide-by-one. The >= lets a
  // count sitting above a shrunk divisor wrap on the next enabled edge.
  always_comb begin
    w_term = (r_div_q == '0) ? '0 : (r_div_q - C_ONE);
    w_hit  = bus.en & (r_count >= w_term);
  end

  prog_clock_divider_count_incrementer #(
    .WIDTH(WIDTH)
  ) u_count_incrementer (
    .i_a  (r_count),
    .o_sum(w_count_inc)
  );

  // Counter, divisor and output registers: reset > load > hit/enable > hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_div_q <= C_DEFAULT_DIV;
      r_tick  <= 1'b0;
      r_out   <= 1'b0;
    end else if (bus.load) begin
      r_div_q <= bus.div_in;
      r_count <= '0;
      r_tick  <= 1'b0;
      if (bus.mode == MODE_PULSE) r_out <= 1'b0;
    end else if (w_hit) begin
      r_count <= '0;
      r_tick  <= 1'b1;
      r_out   <= (bus.mode == MODE_PULSE) ? 1'b1 : ~r_out;
    end else if (bus.en) begin
      r_count <= w_count_inc;
      r_tick  <= 1'b0;
      if (bus.mode == MODE_PULSE) r_out <= 1'b0;
    end else begin
      r_tick  <= 1'b0;
    end
  end

  assign bus.count = r_count;
  assign bus.div_q = r_div_q;
  assign bus.tick  = r_tick;
  assign bus.out   = r_out;

endmodule : prog_clock_divider
`default_nettype wire

// File: tb/tb_prog_clock_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_clock_divider
// Purpose  : Directed self-checking bench for prog_clock_divider
//            (WIDTH=8, DEFAULT_DIV=6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_clock_divider;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  prog_clock_divider_if #(.WIDTH(8)) bus ();

  prog_clock_divider #(
    .WIDTH      (8),
    .DEFAULT_DIV(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic expect_state(input string tag, input int c, input bit t, input bit o);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".tick"},  32'(bus.tick),  32'(t));
    chk({tag, ".out"},   32'(bus.out),   32'(o));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.en     = 1'b0;
    bus.load   = 1'b0;
    bus.div_in = '0;
    bus.mode   = 1'b0;

    // Reset defaults
    step();
    expect_state("reset", 0, 1'b0, 1'b0);
    chk("reset.div_q", 32'(bus.div_q), 32'd6);
    reset  = 1'b0;
    bus.en = 1'b1;

    // Default divide-by-6, toggle mode: tick every 6th edge, out period 12
    for (int k = 1; k <= 24; k++) begin
      step();
      expect_state($sformatf("div6_%0d", k), k % 6, (k % 6) == 0, ((k / 6) % 2) == 1);
    end
    repeat (7) step();
    expect_state("div6_31", 1, 1'b0, 1'b1);

    // Asynchronous reset mid-count clears before any edge
    #1 reset = 1'b1;
    #1;
    expect_state("async_rst", 0, 1'b0, 1'b0);
    chk("async_rst.div_q", 32'(bus.div_q), 32'd6);
    #1 reset = 1'b0;
    step();
    expect_state("resume", 1, 1'b0, 1'b0);

    // Load shrink from count=4 to divisor 3
    repeat (3) step();
    chk("pre_shrink.count", 32'(bus.count), 32'd4);
    bus.load   = 1'b1;
    bus.div_in = 8'd3;
    step();
    bus.load   = 1'b0;
    expect_state("shrink", 0, 1'b0, 1'b0);
    chk("shrink.div_q", 32'(bus.div_q), 32'd3);
    for (int k = 1; k <= 6; k++) begin
      step();
      expect_state($sformatf("div3_%0d", k), k % 3, (k % 3) == 0, ((k / 3) % 2) == 1);
    end

    // Hold at the terminal count with en low, wrap on first enabled edge
    repeat (2) step();
    chk("at_term.count", 32'(bus.count), 32'd2);
    bus.en = 1'b0;
    step();
    expect_state("hold_term1", 2, 1'b0, 1'b0);
    step();
    expect_state("hold_term2", 2, 1'b0, 1'b0);
    bus.en = 1'b1;
    step();
    expect_state("wrap_after_hold", 0, 1'b1, 1'b1);

    // Divisor 0 behaves as divide-by-1
    bus.load   = 1'b1;
    bus.div_in = 8'd0;
    step();
    bus.load   = 1'b0;
    expect_state("load0", 0, 1'b0, 1'b1);
    chk("load0.div_q", 32'(bus.div_q), 32'd0);
    step();
    expect_state("div0_1", 0, 1'b1, 1'b0);
    step();
    expect_state("div0_2", 0, 1'b1, 1'b1);
    step();
    expect_state("div0_3", 0, 1'b1, 1'b0);

    // Divisor 1
    bus.load   = 1'b1;
    bus.div_in = 8'd1;
    step();
    bus.load   = 1'b0;
    expect_state("load1", 0, 1'b0, 1'b0);
    chk("load1.div_q", 32'(bus.div_q), 32'd1);
    step();
    expect_state("div1_1", 0, 1'b1, 1'b1);
    step();
    expect_state("div1_2", 0, 1'b1, 1'b0);

    // Pulse mode, divide-by-4: out equals tick
    bus.mode   = 1'b1;
    bus.load   = 1'b1;
    bus.div_in = 8'd4;
    step();
    bus.load   = 1'b0;
    expect_state("load4", 0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step();
      expect_state($sformatf("pulse4_%0d", k), k % 4, (k % 4) == 0, (k % 4) == 0);
    end
    step();
    expect_state("pulse4_9", 1, 1'b0, 1'b0);

    // Back to toggle mode mid-count: out holds 0 until the next wrap
    bus.mode = 1'b0;
    step();
    expect_state("sw_toggle1", 2, 1'b0, 1'b0);
    step();
    expect_state("sw_toggle2", 3, 1'b0, 1'b0);
    step();
    expect_state("sw_toggle3", 0, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step();
      expect_state($sformatf("tog4_%0d", k), k % 4, k == 4, k != 4);
    end

    // Enable gating at count=2 with divisor 5
    bus.load   = 1'b1;
    bus.div_in = 8'd5;
    step();
    bus.load   = 1'b0;
    expect_state("load5", 0, 1'b0, 1'b0);
    repeat (2) step();
    bus.en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      expect_state($sformatf("gated_%0d", k), 2, 1'b0, 1'b0);
    end
    bus.en = 1'b1;
    step();
    expect_state("ungate1", 3, 1'b0, 1'b0);
    step();
    expect_state("ungate2", 4, 1'b0, 1'b0);
    step();
    expect_state("ungate3", 0, 1'b1, 1'b1);

    // Load collides with the terminal edge: load wins
    repeat (4) step();
    expect_state("pre_collide", 4, 1'b0, 1'b1);
    bus.load   = 1'b1;
    bus.div_in = 8'd10;
    step();
    bus.load   = 1'b0;
    expect_state("collide", 0, 1'b0, 1'b1);
    chk("collide.div_q", 32'(bus.div_q), 32'd10);
    repeat (9) step();
    expect_state("div10_9", 9, 1'b0, 1'b1);
    step();
    expect_state("div10_10", 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_prog_clock_divider
`default_nettype wire
